core_savestate_ctl: RTL and testbench
=====================================

Name: core_savestate_ctl

Overview:
- Sits directly downstream of the bridge host-command handler and consumes its savestate_start / savestate_load request levels.
- Converts each request into a halt-core / transfer / release sequence against the emulated core.
- Returns the ack / busy / ok / err status the handler reports to the host, plus the static savestate geometry words.
- Ensures every request is acked even when another operation is in flight; handles timeouts and simultaneous requests.

Parameters:
SUPPORTED, 1, drives savestate_supported.
SS_ADDR, 32'h0000_0000, bridge address of savestate window; drives savestate_addr.
SS_SIZE, 32'h0001_0000, bytes produced by a save; drives savestate_size.
SS_MAXLOAD, 32'h0001_0000, max bytes accepted on load; drives savestate_maxloadsize.
TIMEOUT, 1_000_000, clk cycles allowed per wait phase (halt ack, transfer done); counter width is $clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock, same domain as bridge command handler
rst  in  1  synchronous, active-high reset
savestate_start  in  1  save request level; rising edge = request
savestate_load  in  1  load request level; rising edge = request
savestate_start_ack  out  1  one-cycle pulse on accepted save request
savestate_start_busy  out  1  save pending or in progress
savestate_start_ok  out  1  sticky: last save succeeded
savestate_start_err  out  1  sticky: last save failed or timed out
savestate_load_ack  out  1  one-cycle pulse on accepted load request
savestate_load_busy  out  1  load pending or in progress
savestate_load_ok  out  1  sticky: last load succeeded
savestate_load_err  out  1  sticky: last load failed or timed out
savestate_supported  out  1  = SUPPORTED
savestate_addr  out  32  = SS_ADDR
savestate_size  out  32  = SS_SIZE
savestate_maxloadsize  out  32  = SS_MAXLOAD
halt_req  out  1  level: core must stop at a safe point
halt_ack  in  1  core halted
ss_save_req  out  1  one-cycle pulse: core begins serialising state
ss_load_req  out  1  one-cycle pulse: core begins restoring state
ss_done  in  1  one-cycle pulse: transfer completed OK
ss_fail  in  1  one-cycle pulse: transfer failed (ss_fail wins if coincident with ss_done)

Behaviour:
- Reset: all 1-bit status outputs, halt_req, ss_save_req, ss_load_req, pending flags and edge registers = 0; state = IDLE; timeout counter = 0. Geometry outputs are constants. Reset mid-operation aborts immediately, drops halt_req, and sets no ok/err.
- Edge detect: previous-level registers on savestate_start / savestate_load. An edge seen at cycle N gives ack = 1 at N+1 only, and sets the matching pending bit at N+1.
- An accepted request clears its own ok/err at N+1. It does not touch the other kind's flags.
- busy_x = pending_x OR (state serving x). Busy rises at N+1 with the ack.
- An edge while the same kind is already pending or active is acked and otherwise ignored: no second operation, flags untouched.
- Arbitration in IDLE: save pending takes priority over load pending. Simultaneous edges: both acked at N+1; save is served first, then load. Pending is consumed on the IDLE to HALT transition.
- States:
  - IDLE: when any pending bit is set, go to HALT, record the kind, set halt_req = 1, clear the counter.
  - HALT: wait for halt_ack = 1, then go to XFER and pulse ss_save_req or ss_load_req for exactly 1 cycle; clear the counter. Counter reaching TIMEOUT: go to RELEASE with result = err.
  - XFER: ss_fail gives result = err, ss_done gives result = ok; both go to RELEASE. Counter reaching TIMEOUT: go to RELEASE with result = err.
  - RELEASE: on entry, halt_req = 0, busy for the served kind = 0, and ok or err = 1 in the same cycle. Stay until halt_ack = 0, then go to IDLE (no timeout here).
- ok and err are never both 1 for one kind. They hold until the next accepted request of that kind or rst.
- Counter increments only in HALT and XFER and saturates at TIMEOUT.

Test Plan:
- Save nominal: start rises at cycle 10; halt_ack returns after 3 cycles; ss_done 20 cycles after ss_save_req. Required: ack only at 11, busy 11 through RELEASE entry, single ss_save_req, start_ok = 1 with busy falling in the same cycle, halt_req 0 after.
- Load fail: load edge; core returns ss_fail. Required: load_err = 1, load_ok = 0, and a later load edge clears err on its ack cycle.
- Simultaneous: both edges in one cycle. Required: both acks next cycle, load_busy held throughout the save, then load runs; order of ss_save_req before ss_load_req checked.
- Timeout: TIMEOUT = 16, halt_ack never asserted. Required: start_err = 1 exactly 16 cycles after entering HALT, halt_req dropped, ss_save_req never pulsed.
- Duplicate edge: second save edge while the first is in XFER. Required: ack pulse, exactly one ss_save_req total, flags unchanged until completion.
- Reset mid-XFER: rst for 1 cycle. Required: all outputs 0 on the following cycle, no ok/err, and a new save then completes normally.

Source files
------------

// File: rtl/core_savestate_ctl.sv
// Savestate sequencer: turns save/load request edges into halt / transfer / release steps against the core.
// Ack one cycle after the request edge; requests queue while another operation runs; every wait phase is bounded by TIMEOUT.
module core_savestate_ctl #(
   parameter bit          SUPPORTED  = 1'b1,
   parameter logic [31:0] SS_ADDR    = 32'h0000_0000,
   parameter logic [31:0] SS_SIZE    = 32'h0001_0000,
   parameter logic [31:0] SS_MAXLOAD = 32'h0001_0000,
   parameter int          TIMEOUT    = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        savestate_start,
   input  logic        savestate_load,
   output logic        savestate_start_ack,
   output logic        savestate_start_busy,
   output logic        savestate_start_ok,
   output logic        savestate_start_err,
   output logic        savestate_load_ack,
   output logic        savestate_load_busy,
   output logic        savestate_load_ok,
   output logic        savestate_load_err,
   output logic        savestate_supported,
   output logic [31:0] savestate_addr,
   output logic [31:0] savestate_size,
   output logic [31:0] savestate_maxloadsize,
   output logic        halt_req,
   input  logic        halt_ack,
   output logic        ss_save_req,
   output logic        ss_load_req,
   input  logic        ss_done,
   input  logic        ss_fail
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_HALT, S_XFER, S_REL} state_t;

   state_t        state, state_d;
   logic          kind_load, kind_load_d;
   logic [CW-1:0] cnt, cnt_d, cnt_inc;
   logic          start_q, load_q;
   logic          pend_s, pend_s_d, pend_l, pend_l_d;
   logic          s_ack_d, l_ack_d;
   logic          s_ok_d, s_err_d, l_ok_d, l_err_d;
   logic          halt_d, save_pulse_d, load_pulse_d;
   logic          start_edge, load_edge, serve_s, serve_l, accept_s, accept_l;
   logic          fin, fin_ok, consume_s, consume_l;

   assign savestate_supported   = SUPPORTED;
   assign savestate_addr        = SS_ADDR;
   assign savestate_size        = SS_SIZE;
   assign savestate_maxloadsize = SS_MAXLOAD;

   assign start_edge = savestate_start & ~start_q;
   assign load_edge  = savestate_load & ~load_q;
   // RELEASE is deliberately not "serving": busy drops on entry, and a fresh edge there queues a new request.
   assign serve_s    = ((state == S_HALT) || (state == S_XFER)) && !kind_load;
   assign serve_l    = ((state == S_HALT) || (state == S_XFER)) && kind_load;
   assign accept_s   = start_edge & ~pend_s & ~serve_s;
   assign accept_l   = load_edge & ~pend_l & ~serve_l;
   assign cnt_inc    = (cnt == TO_MAX) ? cnt : cnt + CW'(1);

   assign savestate_start_busy = pend_s | serve_s;
   assign savestate_load_busy  = pend_l | serve_l;

   always_comb begin
      state_d      = state;
      kind_load_d  = kind_load;
      cnt_d        = cnt;
      halt_d       = halt_req;
      save_pulse_d = 1'b0;
      load_pulse_d = 1'b0;
      fin          = 1'b0;
      fin_ok       = 1'b0;
      consume_s    = 1'b0;
      consume_l    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pend_s || pend_l) begin
               state_d     = S_HALT;
               kind_load_d = !pend_s;
               consume_s   = pend_s;
               consume_l   = !pend_s;
               halt_d      = 1'b1;
               cnt_d       = '0;
            end
         end
         S_HALT: begin
            if (halt_ack) begin
               state_d      = S_XFER;
               save_pulse_d = !kind_load;
               load_pulse_d = kind_load;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TO_MAX) begin
                  state_d = S_REL;
                  halt_d  = 1'b0;
                  fin     = 1'b1;
               end
            end
         end
         S_XFER: begin
            cnt_d = cnt_inc;
            if (ss_fail || ss_done || (cnt_inc == TO_MAX)) begin
               state_d = S_REL;
               halt_d  = 1'b0;
               fin     = 1'b1;
               fin_ok  = ss_done & ~ss_fail;
            end
         end
         S_REL: begin
            if (!halt_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      pend_s_d = (pend_s & ~consume_s) | accept_s;
      pend_l_d = (pend_l & ~consume_l) | accept_l;
      // Any edge is acked, even a duplicate that is otherwise ignored.
      s_ack_d  = start_edge;
      l_ack_d  = load_edge;

      s_ok_d  = savestate_start_ok;
      s_err_d = savestate_start_err;
      l_ok_d  = savestate_load_ok;
      l_err_d = savestate_load_err;
      if (accept_s) begin
         s_ok_d  = 1'b0;
         s_err_d = 1'b0;
      end else if (fin && !kind_load) begin
         s_ok_d  = fin_ok;
         s_err_d = !fin_ok;
      end
      if (accept_l) begin
         l_ok_d  = 1'b0;
         l_err_d = 1'b0;
      end else if (fin && kind_load) begin
         l_ok_d  = fin_ok;
         l_err_d = !fin_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= S_IDLE;
         kind_load           <= 1'b0;
         cnt                 <= '0;
         start_q             <= 1'b0;
         load_q              <= 1'b0;
         pend_s              <= 1'b0;
         pend_l              <= 1'b0;
         savestate_start_ack <= 1'b0;
         savestate_load_ack  <= 1'b0;
         savestate_start_ok  <= 1'b0;
         savestate_start_err <= 1'b0;
         savestate_load_ok   <= 1'b0;
         savestate_load_err  <= 1'b0;
         halt_req            <= 1'b0;
         ss_save_req         <= 1'b0;
         ss_load_req         <= 1'b0;
      end else begin
         state               <= state_d;
         kind_load           <= kind_load_d;
         cnt                 <= cnt_d;
         start_q             <= savestate_start;
         load_q              <= savestate_load;
         pend_s              <= pend_s_d;
         pend_l              <= pend_l_d;
         savestate_start_ack <= s_ack_d;
         savestate_load_ack  <= l_ack_d;
         savestate_start_ok  <= s_ok_d;
         savestate_start_err <= s_err_d;
         savestate_load_ok   <= l_ok_d;
         savestate_load_err  <= l_err_d;
         halt_req            <= halt_d;
         ss_save_req         <= save_pulse_d;
         ss_load_req         <= load_pulse_d;
      end
   end

endmodule

// File: tb/tb_core_savestate_ctl.sv
// Directed bench for core_savestate_ctl; a second instance with TIMEOUT=16 exercises the halt timeout.
module tb_core_savestate_ctl;

   logic clk = 1'b0;
   logic rst, start, load, hack, done, fail, t_start;
   logic s_ack, s_busy, s_ok, s_err, l_ack, l_busy, l_ok, l_err, sup;
   logic [31:0] addr, size, maxl;
   logic halt_req, save_req, load_req;
   logic t_s_ack, t_s_busy, t_s_ok, t_s_err, t_l_ack, t_l_busy, t_l_ok, t_l_err, t_sup;
   logic [31:0] t_addr, t_size, t_maxl;
   logic t_halt, t_save_req, t_load_req;

   int total = 0, bad = 0, cyc = 0;
   int n_save = 0, n_load = 0, t_save = -1, t_load = -1, n_tsave = 0, base;

   always #5 clk = ~clk;

   core_savestate_ctl #(.TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .savestate_start(start), .savestate_load(load),
      .savestate_start_ack(s_ack), .savestate_start_busy(s_busy),
      .savestate_start_ok(s_ok), .savestate_start_err(s_err),
      .savestate_load_ack(l_ack), .savestate_load_busy(l_busy),
      .savestate_load_ok(l_ok), .savestate_load_err(l_err),
      .savestate_supported(sup), .savestate_addr(addr), .savestate_size(size),
      .savestate_maxloadsize(maxl), .halt_req(halt_req), .halt_ack(hack),
      .ss_save_req(save_req), .ss_load_req(load_req), .ss_done(done), .ss_fail(fail)
   );

   core_savestate_ctl #(.TIMEOUT(16)) dut_to (
      .clk(clk), .rst(rst), .savestate_start(t_start), .savestate_load(1'b0),
      .savestate_start_ack(t_s_ack), .savestate_start_busy(t_s_busy),
      .savestate_start_ok(t_s_ok), .savestate_start_err(t_s_err),
      .savestate_load_ack(t_l_ack), .savestate_load_busy(t_l_busy),
      .savestate_load_ok(t_l_ok), .savestate_load_err(t_l_err),
      .savestate_supported(t_sup), .savestate_addr(t_addr), .savestate_size(t_size),
      .savestate_maxloadsize(t_maxl), .halt_req(t_halt), .halt_ack(1'b0),
      .ss_save_req(t_save_req), .ss_load_req(t_load_req), .ss_done(1'b0), .ss_fail(1'b0)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (save_req) begin n_save++; t_save = cyc; end
      if (load_req) begin n_load++; t_load = cyc; end
      if (t_save_req) n_tsave++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 0; load = 0; hack = 0; done = 0; fail = 0; t_start = 0;
      step(2);
      chk("rst_outs", {s_ack, s_busy, s_ok, s_err, l_ack, l_busy, l_ok, l_err, halt_req, save_req, load_req}, 0);
      chk("rst_supported", sup, 1);
      chk("rst_addr", addr, 32'h0000_0000);
      chk("rst_size", size, 32'h0001_0000);
      chk("rst_maxload", maxl, 32'h0001_0000);
      rst = 1'b0;
      step(2);

      // save nominal
      start = 1; step;
      chk("nom_ack", s_ack, 1); chk("nom_busy_ack", s_busy, 1); chk("nom_halt_pre", halt_req, 0);
      step;
      chk("nom_ack_once", s_ack, 0); chk("nom_halt", halt_req, 1); chk("nom_busy_halt", s_busy, 1);
      step(2);
      chk("nom_no_req_yet", save_req, 0);
      hack = 1; step;
      chk("nom_save_req", save_req, 1);
      for (int i = 0; i < 19; i++) begin
         step;
         chk("nom_busy_xfer", s_busy, 1);
         chk("nom_ok_xfer", s_ok, 0);
      end
      done = 1; step; done = 0;
      chk("nom_ok", s_ok, 1); chk("nom_err", s_err, 0);
      chk("nom_busy_rel", s_busy, 0); chk("nom_halt_rel", halt_req, 0);
      hack = 0; start = 0; step(2);
      chk("nom_one_req", n_save, 1); chk("nom_ok_sticky", s_ok, 1); chk("nom_halt_after", halt_req, 0);

      // load fail, then a new load clears err on its ack
      load = 1; step;
      chk("lf_ack", l_ack, 1); chk("lf_busy", l_busy, 1); chk("lf_save_ok_kept", s_ok, 1);
      hack = 1; step;
      chk("lf_halt", halt_req, 1);
      step;
      chk("lf_load_req", load_req, 1); chk("lf_no_save_req", save_req, 0);
      fail = 1; step; fail = 0;
      chk("lf_err", l_err, 1); chk("lf_ok", l_ok, 0); chk("lf_busy_rel", l_busy, 0); chk("lf_halt_rel", halt_req, 0);
      hack = 0; load = 0; step(2);
      load = 1; step;
      chk("lf2_ack", l_ack, 1); chk("lf2_err_clr", l_err, 0);
      hack = 1; step(2);
      done = 1; step; done = 0;
      chk("lf2_ok", l_ok, 1);
      hack = 0; load = 0; step(2);

      // simultaneous edges: save served first, load held busy
      start = 1; load = 1; step;
      chk("sim_acks", {s_ack, l_ack}, 2'b11); chk("sim_busy", {s_busy, l_busy}, 2'b11);
      chk("sim_ok_clr", {s_ok, l_ok}, 2'b00);
      hack = 1; step(2);
      chk("sim_save_req", save_req, 1); chk("sim_lbusy_xfer", l_busy, 1);
      done = 1; step; done = 0;
      chk("sim_save_ok", s_ok, 1); chk("sim_sbusy_rel", s_busy, 0); chk("sim_lbusy_rel", l_busy, 1);
      hack = 0; step; step;
      chk("sim_load_halt", halt_req, 1); chk("sim_lbusy_halt", l_busy, 1);
      hack = 1; step;
      chk("sim_load_req", load_req, 1);
      done = 1; step; done = 0;
      chk("sim_load_ok", l_ok, 1); chk("sim_lbusy_done", l_busy, 0);
      chk("sim_order", (t_save < t_load), 1);
      hack = 0; start = 0; load = 0; step(2);

      // duplicate save edge during XFER
      base = n_save;
      start = 1; step;
      hack = 1; step(2);
      start = 0; step;
      start = 1; step;
      chk("dup_ack", s_ack, 1); chk("dup_busy", s_busy, 1); chk("dup_flags", {s_ok, s_err}, 2'b00);
      start = 0; step;
      chk("dup_ack_once", s_ack, 0);
      step(3);
      done = 1; step; done = 0;
      chk("dup_ok", s_ok, 1); chk("dup_busy_rel", s_busy, 0);
      hack = 0; step(4);
      chk("dup_no_second", {halt_req, s_busy}, 2'b00);
      chk("dup_one_req", n_save - base, 1);

      // reset mid-XFER
      start = 1; step;
      hack = 1; step(2);
      chk("rx_save_req", save_req, 1);
      rst = 1; start = 0; hack = 0; step; rst = 0;
      chk("rx_outs", {s_ack, s_busy, s_ok, s_err, l_ack, l_busy, l_ok, l_err, halt_req, save_req, load_req}, 0);
      step;
      start = 1; step;
      chk("rx_new_ack", s_ack, 1);
      hack = 1; step(2);
      done = 1; step; done = 0;
      chk("rx_new_ok", {s_ok, s_err}, 2'b10);
      hack = 0; start = 0; step(2);

      // halt timeout on the TIMEOUT=16 instance
      t_start = 1; step;
      chk("to_ack", t_s_ack, 1);
      step;
      chk("to_halt", t_halt, 1);
      step(15);
      chk("to_err_early", t_s_err, 0); chk("to_halt_held", t_halt, 1);
      step;
      chk("to_err", t_s_err, 1); chk("to_ok", t_s_ok, 0);
      chk("to_halt_drop", t_halt, 0); chk("to_busy", t_s_busy, 0);
      chk("to_no_save_req", n_tsave, 0);
      t_start = 0; step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
